// File: rtl/comb_checker.sv
// comb_checker: checks NVEC sampled {A,B,C,D}->Y responses of a 4-input combinational DUT against TRUTH.
// Optional first-mismatch capture is built when COMB_CHECKER_FAIL_CAPTURE_EN is defined.
module comb_checker #(
  parameter logic [15:0] TRUTH = 16'hF888,
  parameter int unsigned NVEC  = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       vld,
  input  logic       A,
  input  logic       B,
  input  logic       C,
  input  logic       D,
  input  logic       Y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_cnt,
  output logic [7:0] vec_cnt
`ifdef COMB_CHECKER_FAIL_CAPTURE_EN
  ,
  output logic [7:0] first_fail_idx,
  output logic [4:0] first_fail_vec,
  output logic       fail_seen
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(NVEC - 1);

  state_t     state_q;
  logic       busy_q;
  logic       done_q;
  logic       pass_q;
  logic [7:0] err_cnt_q;
  logic [7:0] vec_cnt_q;

  logic [3:0] vec_idx_s;
  logic       expected_s;
  logic       mismatch_s;
  logic       last_vec_s;
  logic [7:0] err_inc_s;

`ifdef COMB_CHECKER_FAIL_CAPTURE_EN
  logic [7:0] first_fail_idx_q;
  logic [4:0] first_fail_vec_q;
  logic       fail_seen_q;
`endif

  // Reference lookup, mismatch detect and saturating error increment
  always_comb begin
    vec_idx_s  = {A, B, C, D};
    expected_s = TRUTH[vec_idx_s];
    mismatch_s = expected_s ^ Y;
    last_vec_s = (vec_cnt_q == LAST_IDX);
    if (err_cnt_q == 8'hFF) begin
      err_inc_s = 8'hFF;
    end else begin
      err_inc_s = err_cnt_q + 8'd1;
    end
  end

  // Run-control FSM with registered status outputs and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      err_cnt_q <= 8'd0;
      vec_cnt_q <= 8'd0;
`ifdef COMB_CHECKER_FAIL_CAPTURE_EN
      first_fail_idx_q <= 8'd0;
      first_fail_vec_q <= 5'd0;
      fail_seen_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        // A start here wins over a coincident vld, which is dropped
        IDLE, DONE: begin
          if (start) begin
            state_q   <= RUN;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            err_cnt_q <= 8'd0;
            vec_cnt_q <= 8'd0;
`ifdef COMB_CHECKER_FAIL_CAPTURE_EN
            first_fail_idx_q <= 8'd0;
            first_fail_vec_q <= 5'd0;
            fail_seen_q      <= 1'b0;
`endif
          end
        end
        RUN: begin
          if (vld) begin
            vec_cnt_q <= vec_cnt_q + 8'd1;
            if (mismatch_s) begin
              err_cnt_q <= err_inc_s;
`ifdef COMB_CHECKER_FAIL_CAPTURE_EN
              if (!fail_seen_q) begin
                first_fail_idx_q <= vec_cnt_q;
                first_fail_vec_q <= {A, B, C, D, Y};
                fail_seen_q      <= 1'b1;
              end
`endif
            end
            if (last_vec_s) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (err_cnt_q == 8'd0) && !mismatch_s;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          pass_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign pass    = pass_q;
  assign err_cnt = err_cnt_q;
  assign vec_cnt = vec_cnt_q;

`ifdef COMB_CHECKER_FAIL_CAPTURE_EN
  assign first_fail_idx = first_fail_idx_q;
  assign first_fail_vec = first_fail_vec_q;
  assign fail_seen      = fail_seen_q;
`endif

endmodule

// File: tb/tb_comb_checker.sv
// Self-checking bench for comb_checker: a 5-vector and a 255-vector instance against a run-level model.
module tb_comb_checker;

  logic clk = 1'b0;
  logic rst_n, start5, start255, vld, A, B, C, D, Y;
  logic busy5, done5, pass5, busy255, done255, pass255;
  logic [7:0] err5, vec5, err255, vec255;
`ifdef COMB_CHECKER_FAIL_CAPTURE_EN
  logic [7:0] ffi5, ffi255;
  logic [4:0] ffv5, ffv255;
  logic fs5, fs255;
`endif

  always #5 clk = ~clk;

  comb_checker u_dut5 (
    .clk(clk), .rst_n(rst_n), .start(start5), .vld(vld),
    .A(A), .B(B), .C(C), .D(D), .Y(Y),
    .busy(busy5), .done(done5), .pass(pass5), .err_cnt(err5), .vec_cnt(vec5)
`ifdef COMB_CHECKER_FAIL_CAPTURE_EN
    , .first_fail_idx(ffi5), .first_fail_vec(ffv5), .fail_seen(fs5)
`endif
  );

  comb_checker #(.TRUTH(16'hF888), .NVEC(255)) u_dut255 (
    .clk(clk), .rst_n(rst_n), .start(start255), .vld(vld),
    .A(A), .B(B), .C(C), .D(D), .Y(Y),
    .busy(busy255), .done(done255), .pass(pass255), .err_cnt(err255), .vec_cnt(vec255)
`ifdef COMB_CHECKER_FAIL_CAPTURE_EN
    , .first_fail_idx(ffi255), .first_fail_vec(ffv255), .fail_seen(fs255)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;
  bit sel = 1'b0;   // 0: 5-vector instance, 1: 255-vector instance

  // Run-level model: is a run active, has one finished, how many samples and misses
  int   m_nvec = 5;
  bit   m_run, m_done, m_fseen;
  int   m_vec, m_err, m_ffi;
  logic [4:0] m_ffv;

  logic [18:0] o_stat;
  logic [13:0] o_cap;
  assign o_stat = sel ? {busy255, done255, pass255, err255, vec255}
                      : {busy5, done5, pass5, err5, vec5};
`ifdef COMB_CHECKER_FAIL_CAPTURE_EN
  assign o_cap = sel ? {ffi255, ffv255, fs255} : {ffi5, ffv5, fs5};
`else
  assign o_cap = 14'd0;
`endif

  function automatic logic [18:0] exp_stat();
    return {m_run, m_done, m_done && (m_err == 0), 8'(m_err), 8'(m_vec)};
  endfunction

  function automatic logic [13:0] exp_cap();
    return {8'(m_ffi), m_ffv, m_fseen};
  endfunction

  function automatic logic ref_y(input logic [3:0] abcd);
    return (abcd[3] & abcd[2]) | (abcd[1] & abcd[0]);
  endfunction

  task automatic model_clear();
    m_run = 1'b0; m_done = 1'b0; m_vec = 0; m_err = 0;
    m_fseen = 1'b0; m_ffi = 0; m_ffv = 5'd0;
  endtask

  // One clock: drive at negedge, update the model for the rising edge, settle 1 ns after it
  task automatic cyc(input bit s, input bit v, input logic [3:0] abcd, input logic y);
    @(negedge clk);
    start5 = s && !sel; start255 = s && sel; vld = v;
    {A, B, C, D} = abcd; Y = y;
    if (!m_run) begin
      if (s) begin
        model_clear();
        m_run = 1'b1;
      end
    end else if (v) begin
      if (ref_y(abcd) != y) begin
        if (!m_fseen) begin
          m_fseen = 1'b1; m_ffi = m_vec; m_ffv = {abcd, y};
        end
        m_err = (m_err + 1 > 255) ? 255 : m_err + 1;
      end
      m_vec++;
      if (m_vec == m_nvec) begin
        m_run = 1'b0; m_done = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if ({busy5, done5, pass5, err5, vec5} !== 19'd0) begin
      n_errors++; $display("FAIL reset5 got %h want 00000", {busy5, done5, pass5, err5, vec5});
    end
    n_checks++;
    if ({busy255, done255, pass255, err255, vec255} !== 19'd0) begin
      n_errors++; $display("FAIL reset255 got %h want 00000", {busy255, done255, pass255, err255, vec255});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_ignore_idle();
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b1, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      n_checks++;
      if (o_stat !== exp_stat()) begin
        n_errors++; $display("FAIL ignore_idle cyc %0d got %h want %h", i, o_stat, exp_stat());
      end
    end
  endtask

  task automatic test_directed(input bit fault);
    logic [3:0] v_abcd [5];
    logic       v_y    [5];
    v_abcd = '{4'b0000, 4'b1100, 4'b0011, 4'b1111, 4'b1010};
    v_y    = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    if (fault) v_y[2] = 1'b0;
    cyc(1'b1, 1'b0, 4'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b1, v_abcd[i], v_y[i]);
      n_checks++;
      if (o_stat !== exp_stat()) begin
        n_errors++; $display("FAIL directed fault=%0d vec %0d got %h want %h", fault, i, o_stat, exp_stat());
      end
    end
    n_checks++;
    if (o_stat !== {1'b0, 1'b1, !fault, 8'(fault), 8'd5}) begin
      n_errors++; $display("FAIL directed_end fault=%0d got %h want %h", fault, o_stat, {1'b0, 1'b1, !fault, 8'(fault), 8'd5});
    end
`ifdef COMB_CHECKER_FAIL_CAPTURE_EN
    n_checks++;
    if (o_cap !== (fault ? {8'd2, 5'b00110, 1'b1} : 14'd0)) begin
      n_errors++; $display("FAIL capture fault=%0d got %h want %h", fault, o_cap, fault ? {8'd2, 5'b00110, 1'b1} : 14'd0);
    end
`endif
    cyc(1'b0, 1'b0, 4'd0, 1'b0);
    n_checks++;
    if (o_stat !== exp_stat()) begin
      n_errors++; $display("FAIL done_hold fault=%0d got %h want %h", fault, o_stat, exp_stat());
    end
  endtask

  task automatic test_random();
    logic [3:0] abcd;
    for (int r = 0; r < 6; r++) begin
      cyc(1'b1, 1'b0, 4'd0, 1'b0);
      while (m_run) begin
        abcd = 4'($urandom_range(0, 15));
        cyc(1'b0, ($urandom_range(0, 3) != 0), abcd, ref_y(abcd) ^ ($urandom_range(0, 3) == 0));
        n_checks++;
        if (o_stat !== exp_stat()) begin
          n_errors++; $display("FAIL random run %0d got %h want %h", r, o_stat, exp_stat());
        end
        n_checks++;
        if (o_cap !== exp_cap() && o_cap !== 14'd0) begin
          n_errors++; $display("FAIL random_cap run %0d got %h want %h", r, o_cap, exp_cap());
        end
      end
    end
  endtask

  task automatic test_start_in_run();
    cyc(1'b1, 1'b0, 4'd0, 1'b0);
    cyc(1'b0, 1'b1, 4'b1100, 1'b1);
    cyc(1'b0, 1'b1, 4'b0001, 1'b0);
    cyc(1'b1, 1'b0, 4'd0, 1'b0);
    n_checks++;
    if (o_stat !== {1'b1, 1'b0, 1'b0, 8'd0, 8'd2}) begin
      n_errors++; $display("FAIL start_in_run got %h want %h", o_stat, {1'b1, 1'b0, 1'b0, 8'd0, 8'd2});
    end
    cyc(1'b1, 1'b1, 4'b0111, 1'b0);
    n_checks++;
    if (o_stat !== {1'b1, 1'b0, 1'b0, 8'd1, 8'd3}) begin
      n_errors++; $display("FAIL start_vld_in_run got %h want %h", o_stat, {1'b1, 1'b0, 1'b0, 8'd1, 8'd3});
    end
    cyc(1'b0, 1'b1, 4'b1111, 1'b1);
    cyc(1'b0, 1'b1, 4'b0000, 1'b0);
    n_checks++;
    if (o_stat !== exp_stat()) begin
      n_errors++; $display("FAIL start_in_run_end got %h want %h", o_stat, exp_stat());
    end
  endtask

  task automatic test_start_vld_done();
    cyc(1'b1, 1'b1, 4'b0000, 1'b1);
    n_checks++;
    if (o_stat !== {1'b1, 1'b0, 1'b0, 8'd0, 8'd0}) begin
      n_errors++; $display("FAIL start_vld_done got %h want %h", o_stat, {1'b1, 1'b0, 1'b0, 8'd0, 8'd0});
    end
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 4'(i * 3), ref_y(4'(i * 3)));
    n_checks++;
    if (o_stat !== {1'b0, 1'b1, 1'b1, 8'd0, 8'd5}) begin
      n_errors++; $display("FAIL start_vld_done_run got %h want %h", o_stat, {1'b0, 1'b1, 1'b1, 8'd0, 8'd5});
    end
  endtask

  task automatic test_reset_mid_run();
    cyc(1'b1, 1'b0, 4'd0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 4'b0011, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0; start5 = 1'b0; vld = 1'b0;
    model_clear();
    #1;
    n_checks++;
    if (o_stat !== 19'd0) begin
      n_errors++; $display("FAIL reset_mid_run got %h want 00000", o_stat);
    end
    n_checks++;
    if (o_cap !== 14'd0) begin
      n_errors++; $display("FAIL reset_mid_run_cap got %h want 0000", o_cap);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b0, 1'b1, 4'b1111, 1'b0);
    n_checks++;
    if (o_stat !== 19'd0) begin
      n_errors++; $display("FAIL post_reset_idle got %h want 00000", o_stat);
    end
    test_directed(1'b0);
  endtask

  task automatic test_saturation();
    logic [3:0] abcd;
    sel = 1'b1; m_nvec = 255;
    model_clear();
    for (int run = 0; run < 2; run++) begin
      cyc(1'b1, 1'b0, 4'd0, 1'b0);
      n_checks++;
      if (o_stat !== {1'b1, 1'b0, 1'b0, 8'd0, 8'd0}) begin
        n_errors++; $display("FAIL sat_start run %0d got %h want %h", run, o_stat, {1'b1, 1'b0, 1'b0, 8'd0, 8'd0});
      end
      for (int i = 0; i < 255; i++) begin
        abcd = 4'($urandom_range(0, 15));
        cyc(1'b0, 1'b1, abcd, !ref_y(abcd));
      end
      n_checks++;
      if (o_stat !== {1'b0, 1'b1, 1'b0, 8'd255, 8'd255}) begin
        n_errors++; $display("FAIL sat_end run %0d got %h want %h", run, o_stat, {1'b0, 1'b1, 1'b0, 8'd255, 8'd255});
      end
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 4'b0000, 1'b1);
      n_checks++;
      if (o_stat !== exp_stat() || err255 !== 8'd255) begin
        n_errors++; $display("FAIL sat_extra_vld run %0d got %h want %h", run, o_stat, exp_stat());
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; start5 = 1'b0; start255 = 1'b0; vld = 1'b0;
    A = 1'b0; B = 1'b0; C = 1'b0; D = 1'b0; Y = 1'b0;
    model_clear();
    test_reset();
    test_ignore_idle();
    test_directed(1'b0);
    test_directed(1'b1);
    test_start_in_run();
    test_start_vld_done();
    test_random();
    test_reset_mid_run();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
